// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1-style serial transmitter with valid/ready byte intake
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]           state;
    logic [CW-1:0]        baud_cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 tx_q;
    logic                 done_q;

    // Handshake and status flags are pure decodes of the state register.
    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign tx       = tx_q;
    assign tx_done  = done_q;

    // Frame sequencer: the line bit is registered so it only moves on bit
    // boundaries; the shift register is consumed LSB first, one bit per
    // baud period, so later changes on tx_data cannot reach the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shreg    <= tx_data;
                        tx_q     <= 1'b0;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx_q     <= shreg[0];
                        shreg    <= shreg >> 1;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            tx_q    <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                            tx_q    <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        done_q   <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    tx_q     <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
